ps2_keyboard_tx: RTL and testbench

Device-side PS/2 frame generator: accepts keyboard scan-code bytes through a valid/ready handshake, buffers them in an 8-entry FIFO and serialises each byte as an 11-bit PS/2 frame. It drives both `ps2_clk` and `ps2_data`, so it acts as the keyboard end of the link. It feeds the existing PS/2 keyboard receiver in simulation and FPGA loopback tests, and serves as the scan-code source for keyboard emulation.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_fifo.sv | 49 ++++
 rtl/ps2_keyboard_tx.sv | 134 +++++++++++++
 tb/tb_ps2_keyboard_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, tx FSM states and frame/parity helpers.
package ps2_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_GAP  = 3'd4
  } ps2_tx_state_t;

  function automatic logic ps2_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Bit 0 goes on the wire first.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {PS2_STOP, ps2_parity(b), b, PS2_START};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO, power-of-2 depth; pushes while full and pops while empty are ignored.
module ps2_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_en, pop_en;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_en   = push_i && !full_o;
  assign pop_en    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: FIFO-buffered scan codes serialised as 11-bit frames,
// driving both ps2_clk and ps2_data from flops.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 200,
  parameter int DEPTH      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       sent
);

  localparam int                 DIV_W    = $clog2(CLK_DIV);
  localparam int                 GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]         LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_t               state_q, state_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic [3:0]                  bit_idx_q, bit_idx_d;
  logic [PS2_FRAME_BITS-1:0]   shift_q, shift_d;
  logic                        ps2_clk_q, ps2_data_q, ps2_data_d;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_dat;
  logic       start_ok;

  ps2_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (valid),
    .push_dat_i (data_in),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign start_ok = !fifo_empty && !inhibit;
  assign ready    = !fifo_full;
  assign busy     = (state_q != ST_IDLE);
  assign sent     = (state_q == ST_GAP) && (gap_q == GAP_LAST);
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    gap_d     = gap_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_LOAD;
      ST_LOAD: begin
        fifo_pop  = 1'b1;
        shift_d   = ps2_frame(fifo_dat);
        bit_idx_d = '0;
        div_d     = '0;
        state_d   = ST_HIGH;
      end
      ST_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ST_LOW;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            shift_d   = shift_q >> 1;
            state_d   = ST_HIGH;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        // The idle decision is folded into the last gap cycle so back-to-back
        // frames lose no cycle between sent and the next LOAD.
        if (gap_q == GAP_LAST) begin
          state_d = start_ok ? ST_LOAD : ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ps2_data_d = ((state_d == ST_HIGH) || (state_d == ST_LOW)) ? shift_d[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      gap_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      ps2_clk_q  <= (state_d != ST_LOW);
      ps2_data_q <= ps2_data_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Randomised scoreboard bench: a behavioural PS/2 receiver decodes the wire and checks
// each frame against the bytes accepted by the handshake, plus timing/inhibit/reset cases.
module tb_ps2_keyboard_tx;

  localparam int DIV_A   = 5;
  localparam int GAP_A   = 12;
  localparam int FRAME_A = 1 + 22 * DIV_A + GAP_A;
  localparam int DIV_B   = 2;
  localparam int GAP_B   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, inhibit, ready, ps2_clk, ps2_data, busy, sent;
  logic [7:0] data_in;
  logic       rst_b, valid_b, inhibit_b, ready_b, ps2_clk_b, ps2_data_b, busy_b, sent_b;
  logic [7:0] data_b;

  ps2_keyboard_tx #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A), .DEPTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .ready(ready),
    .inhibit(inhibit), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .sent(sent)
  );

  ps2_keyboard_tx #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B), .DEPTH(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .data_in(data_b), .valid(valid_b), .ready(ready_b),
    .inhibit(inhibit_b), .ps2_clk(ps2_clk_b), .ps2_data(ps2_data_b), .busy(busy_b), .sent(sent_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_q[$];
  logic [10:0] got_frames[$];
  int          sent_cyc[$];
  int          first_fall_cyc[$];
  int          n_sent = 0, n_falls = 0, frames_done = 0;
  int          nb = 0;
  logic [10:0] fb;
  logic        prev_clk = 1'b1, prev_data = 1'b1, stable_ok = 1'b1;

  int sent_b_cyc[$];
  int fall_at_sent_b[$];
  int falls_b = 0;
  logic prev_clk_b = 1'b1;

  // Reference: odd parity means the 9 bits data+parity hold an odd number of ones.
  function automatic logic model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_frame(input logic [10:0] f);
    logic [7:0] e;
    got_frames.push_back(f);
    frames_done++;
    chk("frame_start_stop", {f[10], f[0]}, 2'b10);
    chk("frame_data_stable", stable_ok, 1'b1);
    stable_ok = 1'b1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got byte %0h, want none", f[8:1]);
    end else begin
      e = exp_q.pop_front();
      chk("frame_byte", f[8:1], e);
      chk("frame_parity", f[9], model_parity(e));
    end
  endtask

  always @(negedge clk) begin
    if (sent) begin
      n_sent++;
      sent_cyc.push_back(cyc);
    end
    if (!prev_clk && !ps2_clk && (ps2_data !== prev_data)) stable_ok = 1'b0;
    if (prev_clk && !ps2_clk) begin
      n_falls++;
      if (nb == 0) first_fall_cyc.push_back(cyc);
      fb[nb] = ps2_data;
      nb++;
      if (nb == 11) begin
        check_frame(fb);
        nb = 0;
      end
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  always @(negedge clk) begin
    if (prev_clk_b && !ps2_clk_b) falls_b++;
    prev_clk_b = ps2_clk_b;
    if (sent_b) begin
      sent_b_cyc.push_back(cyc);
      fall_at_sent_b.push_back(falls_b);
    end
  end

  task automatic push(input logic [7:0] b, input logic hold);
    int k = 0;
    @(negedge clk);
    data_in = b;
    valid   = 1'b1;
    #1;
    while (!ready && k < 5000) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready %0b, want 1", ready);
    end else begin
      exp_q.push_back(b);
      @(posedge clk);
    end
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while (n_sent < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_sent_reached", (n_sent >= n), 1'b1);
  endtask

  initial begin
    int          n, k, s0, f0, ff0, fl0;
    logic [7:0]  b9;
    logic [10:0] want;
    int          seq[11];

    rst = 1'b1; valid = 1'b0; inhibit = 1'b0; data_in = '0;
    rst_b = 1'b1; valid_b = 1'b0; inhibit_b = 1'b0; data_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ps2_clk", ps2_clk, 1'b1);
    chk("reset_ps2_data", ps2_data, 1'b1);
    chk("reset_ready", ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sent", sent, 1'b0);
    rst = 1'b0;
    rst_b = 1'b0;

    // Minimal-timing instance: three queued bytes run back to back.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_b  = 8'($urandom);
      valid_b = 1'b1;
    end
    @(negedge clk);
    valid_b = 1'b0;
    k = 0;
    while (sent_b_cyc.size() < 3 && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("b_three_sent", (sent_b_cyc.size() >= 3), 1'b1);
    if (sent_b_cyc.size() >= 3) begin
      chk("b_frame_len_1", sent_b_cyc[1] - sent_b_cyc[0], 46);
      chk("b_frame_len_2", sent_b_cyc[2] - sent_b_cyc[1], 46);
      chk("b_falls_frame_1", fall_at_sent_b[0], 11);
      chk("b_falls_frame_2", fall_at_sent_b[1] - fall_at_sent_b[0], 11);
    end

    // 0x1C: wire sequence and first-edge latency.
    push(8'h1C, 1'b0);
    n = 0;
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (!ps2_clk) break;
      @(posedge clk);
      n++;
      k++;
    end
    chk("first_fall_latency", n, DIV_A + 2);
    wait_sent(1, 2 * FRAME_A);
    seq = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 11; i++) want[i] = seq[i][0];
    if (got_frames.size() >= 1) chk("seq_0x1c", got_frames[got_frames.size() - 1], want);

    // 0x00 then 0xFF: both parities 1, back to back.
    s0 = sent_cyc.size();
    ff0 = first_fall_cyc.size();
    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    wait_sent(n_sent + 2, 3 * FRAME_A);
    if (got_frames.size() >= 2 && sent_cyc.size() >= s0 + 2 && first_fall_cyc.size() >= ff0 + 2) begin
      chk("parity_0x00", got_frames[got_frames.size() - 2][9], 1'b1);
      chk("parity_0xff", got_frames[got_frames.size() - 1][9], 1'b1);
      chk("b2b_load_after_sent", first_fall_cyc[ff0 + 1] - sent_cyc[s0], DIV_A + 2);
      chk("frame_len_a", sent_cyc[s0 + 1] - sent_cyc[s0], FRAME_A);
    end

    // Fill the FIFO while inhibited; ninth byte must be held off.
    s0 = n_sent;
    @(negedge clk);
    inhibit = 1'b1;
    for (int i = 0; i < 8; i++) push(8'($urandom), 1'b1);
    @(negedge clk);
    chk("full_ready_low", ready, 1'b0);
    b9 = 8'($urandom);
    data_in = b9;
    repeat (20) @(negedge clk);
    chk("ninth_held_ready", ready, 1'b0);
    chk("inhibit_idle_busy", busy, 1'b0);
    chk("inhibit_no_frames", n_sent, s0);
    inhibit = 1'b0;
    push(b9, 1'b0);
    wait_sent(s0 + 9, 10 * FRAME_A);
    chk("nine_frames_drained", exp_q.size(), 0);

    // Inhibit raised during frame 1 of 2.
    s0 = n_sent;
    f0 = frames_done;
    push(8'($urandom), 1'b0);
    push(8'($urandom), 1'b0);
    k = 0;
    while (ps2_clk && k < 200) begin
      @(negedge clk);
      k++;
    end
    inhibit = 1'b1;
    wait_sent(s0 + 1, 2 * FRAME_A);
    repeat (3 * FRAME_A) @(negedge clk);
    chk("inhibit_frame1_only", frames_done - f0, 1);
    chk("inhibit_holds_frame2", busy, 1'b0);
    inhibit = 1'b0;
    wait_sent(s0 + 2, 2 * FRAME_A);
    chk("inhibit_frame2_after", frames_done - f0, 2);

    // Random bytes with random spacing.
    s0 = n_sent;
    for (int i = 0; i < 16; i++) begin
      push(8'($urandom), 1'b0);
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end
    wait_sent(s0 + 16, 17 * FRAME_A);
    chk("random_drained", exp_q.size(), 0);
    chk("sent_matches_frames", n_sent, frames_done);

    // Reset at the 5th falling edge with more bytes still queued.
    push(8'($urandom), 1'b0);
    push(8'($urandom), 1'b0);
    push(8'($urandom), 1'b0);
    k = 0;
    while (nb != 5 && k < 2 * FRAME_A) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reached_5th_fall", nb, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ps2_clk", ps2_clk, 1'b1);
    chk("midrst_ps2_data", ps2_data, 1'b1);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    exp_q.delete();
    nb = 0;
    stable_ok = 1'b1;
    fl0 = n_falls;
    s0 = n_sent;
    rst = 1'b0;
    repeat (4 * FRAME_A) @(negedge clk);
    chk("midrst_no_edges", n_falls, fl0);
    chk("midrst_no_sent", n_sent, s0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
